// File: rtl/mii_rx_framer.sv
`timescale 1ns/1ps
// MII receive framer: finds preamble/SFD, packs nibbles into bytes, holds the
// last four bytes back so the FCS is never forwarded, checks CRC-32, and keeps
// wrapping frame-status counters.
//
// state  | meaning
// S_WAIT | after reset, wait for a gap so a frame in flight is ignored
// S_IDLE | between frames, waiting for the first preamble nibble
// S_PRE  | counting 0x5 preamble nibbles, looking for the 0xD SFD nibble
// S_LO   | expecting the low nibble of a frame byte
// S_HI   | expecting the high nibble of a frame byte
// S_DROP | discarding the rest of a rejected/errored frame until RX_DV falls
module mii_rx_framer #(
  parameter int unsigned MIN_PREAMBLE = 2,
  parameter int unsigned MIN_FRAME    = 64
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       rxValid,
  input  logic       rxDv,
  input  logic       rxEr,
  input  logic [3:0] rxd,
  output logic       newpkt,
  output logic       dataValid,
  output logic [7:0] data,
  output logic       frameEnd,
  output logic       crcOk,
  output logic [7:0] goodFrames,
  output logic [7:0] badCrc,
  output logic [7:0] runts,
  output logic [7:0] errFrames
);

  localparam logic [3:0]  MIN_PRE_C   = 4'(MIN_PREAMBLE);
  localparam logic [10:0] MIN_FRAME_C = 11'(MIN_FRAME);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    S_WAIT, S_IDLE, S_PRE, S_LO, S_HI, S_DROP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      pre_cnt_q, pre_cnt_d;
  logic [3:0]      lo_q, lo_d;
  logic [31:0]     crc_q, crc_d;
  logic [10:0]     byte_cnt_q, byte_cnt_d;
  logic [3:0][7:0] dl_q, dl_d;          // index 0 newest, index 3 oldest
  logic [2:0]      dl_cnt_q, dl_cnt_d;
  logic            newpkt_q, newpkt_d;
  logic            data_valid_q, data_valid_d;
  logic [7:0]      data_q, data_d;
  logic            frame_end_q, frame_end_d;
  logic            crc_ok_q, crc_ok_d;
  logic [7:0]      good_frames_q, good_frames_d;
  logic [7:0]      bad_crc_q, bad_crc_d;
  logic [7:0]      runts_q, runts_d;
  logic [7:0]      err_frames_q, err_frames_d;
  logic [7:0]      byte_w;

  // Reflected CRC-32 update over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] b);
    logic [31:0] c;
    c = crc_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Next-state, datapath and pulse generation; only acts on nibble strobes.
  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    lo_d          = lo_q;
    crc_d         = crc_q;
    byte_cnt_d    = byte_cnt_q;
    dl_d          = dl_q;
    dl_cnt_d      = dl_cnt_q;
    newpkt_d      = 1'b0;
    data_valid_d  = 1'b0;
    data_d        = data_q;
    frame_end_d   = 1'b0;
    crc_ok_d      = crc_ok_q;
    good_frames_d = good_frames_q;
    bad_crc_d     = bad_crc_q;
    runts_d       = runts_q;
    err_frames_d  = err_frames_q;
    byte_w        = {rxd, lo_q};

    if (rxValid) begin
      case (state_q)
        S_WAIT: begin
          if (!rxDv) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (rxDv) begin
            if (rxd == 4'h5) begin
              state_d   = S_PRE;
              pre_cnt_d = 4'd1;
            end else begin
              state_d = S_DROP;
            end
          end
        end
        S_PRE: begin
          if (!rxDv) begin
            state_d = S_IDLE;
          end else if (rxEr) begin
            state_d = S_DROP;
          end else if (rxd == 4'h5) begin
            if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
          end else if (rxd == 4'hD && pre_cnt_q >= MIN_PRE_C) begin
            state_d    = S_LO;
            newpkt_d   = 1'b1;
            crc_d      = 32'hFFFFFFFF;
            byte_cnt_d = 11'd0;
            dl_d       = '0;
            dl_cnt_d   = 3'd0;
          end else begin
            state_d = S_DROP;
          end
        end
        S_LO: begin
          if (!rxDv) begin
            // Clean end on a byte boundary: exactly one counter moves.
            state_d     = S_IDLE;
            frame_end_d = 1'b1;
            crc_ok_d    = 1'b0;
            if (byte_cnt_q < MIN_FRAME_C) begin
              runts_d = runts_q + 8'd1;
            end else if (crc_q != CRC_RESIDUE) begin
              bad_crc_d = bad_crc_q + 8'd1;
            end else begin
              good_frames_d = good_frames_q + 8'd1;
              crc_ok_d      = 1'b1;
            end
          end else if (rxEr) begin
            state_d      = S_DROP;
            frame_end_d  = 1'b1;
            crc_ok_d     = 1'b0;
            err_frames_d = err_frames_q + 8'd1;
          end else begin
            lo_d    = rxd;
            state_d = S_HI;
          end
        end
        S_HI: begin
          if (!rxDv) begin
            // Frame stopped on a half byte.
            state_d      = S_IDLE;
            frame_end_d  = 1'b1;
            crc_ok_d     = 1'b0;
            err_frames_d = err_frames_q + 8'd1;
          end else if (rxEr) begin
            state_d      = S_DROP;
            frame_end_d  = 1'b1;
            crc_ok_d     = 1'b0;
            err_frames_d = err_frames_q + 8'd1;
          end else begin
            state_d = S_LO;
            crc_d   = crc_byte(crc_q, byte_w);
            if (byte_cnt_q != 11'h7FF) byte_cnt_d = byte_cnt_q + 11'd1;
            // Once four bytes are held, each new byte releases the oldest.
            if (dl_cnt_q == 3'd4) begin
              data_valid_d = 1'b1;
              data_d       = dl_q[3];
            end else begin
              dl_cnt_d = dl_cnt_q + 3'd1;
            end
            dl_d = {dl_q[2:0], byte_w};
          end
        end
        S_DROP: begin
          if (!rxDv) state_d = S_IDLE;
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= S_WAIT;
      pre_cnt_q     <= 4'd0;
      lo_q          <= 4'd0;
      crc_q         <= 32'hFFFFFFFF;
      byte_cnt_q    <= 11'd0;
      dl_q          <= '0;
      dl_cnt_q      <= 3'd0;
      newpkt_q      <= 1'b0;
      data_valid_q  <= 1'b0;
      data_q        <= 8'd0;
      frame_end_q   <= 1'b0;
      crc_ok_q      <= 1'b0;
      good_frames_q <= 8'd0;
      bad_crc_q     <= 8'd0;
      runts_q       <= 8'd0;
      err_frames_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      lo_q          <= lo_d;
      crc_q         <= crc_d;
      byte_cnt_q    <= byte_cnt_d;
      dl_q          <= dl_d;
      dl_cnt_q      <= dl_cnt_d;
      newpkt_q      <= newpkt_d;
      data_valid_q  <= data_valid_d;
      data_q        <= data_d;
      frame_end_q   <= frame_end_d;
      crc_ok_q      <= crc_ok_d;
      good_frames_q <= good_frames_d;
      bad_crc_q     <= bad_crc_d;
      runts_q       <= runts_d;
      err_frames_q  <= err_frames_d;
    end
  end

  assign newpkt     = newpkt_q;
  assign dataValid  = data_valid_q;
  assign data       = data_q;
  assign frameEnd   = frame_end_q;
  assign crcOk      = crc_ok_q;
  assign goodFrames = good_frames_q;
  assign badCrc     = bad_crc_q;
  assign runts      = runts_q;
  assign errFrames  = err_frames_q;

endmodule

// File: tb/tb_mii_rx_framer.sv
`timescale 1ns/1ps
// Directed bench for mii_rx_framer: builds frames with their own FCS, drives
// them as nibbles with idle strobes mixed in, and checks emitted bytes,
// pulses and counters.
module tb_mii_rx_framer;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       rxValid = 1'b0;
  logic       rxDv = 1'b0;
  logic       rxEr = 1'b0;
  logic [3:0] rxd = 4'h0;
  logic       newpkt, dataValid, frameEnd, crcOk;
  logic [7:0] data, goodFrames, badCrc, runts, errFrames;

  mii_rx_framer #(.MIN_PREAMBLE(2), .MIN_FRAME(64)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .rxValid(rxValid), .rxDv(rxDv), .rxEr(rxEr),
    .rxd(rxd), .newpkt(newpkt), .dataValid(dataValid), .data(data),
    .frameEnd(frameEnd), .crcOk(crcOk), .goodFrames(goodFrames),
    .badCrc(badCrc), .runts(runts), .errFrames(errFrames)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int         np_tot = 0, fe_tot = 0, dv_tot = 0, both_tot = 0;
  logic       fe_ok = 1'b0;
  logic [7:0] rx_mem [0:1023];

  always @(negedge CLOCK) begin
    if (newpkt) np_tot++;
    if (newpkt && dataValid) both_tot++;
    if (frameEnd) begin
      fe_tot++;
      fe_ok = crcOk;
    end
    if (dataValid) begin
      if (dv_tot < 1024) rx_mem[dv_tot] = data;
      dv_tot++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [7:0] tx_q[$];
  int stall_ctr = 0;
  int np0, fe0, dv0;

  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Frame of n bytes 0,1,2.. plus FCS; optionally flip bit 0 of one byte after FCS is computed.
  task automatic make_frame(input int n, input int flip);
    logic [31:0] c;
    logic [31:0] fcs;
    tx_q.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(8'(i));
      c = crc_bits(c, 8'(i));
    end
    fcs = ~c;
    if (flip >= 0) tx_q[flip] = tx_q[flip] ^ 8'h01;
    tx_q.push_back(fcs[7:0]);
    tx_q.push_back(fcs[15:8]);
    tx_q.push_back(fcs[23:16]);
    tx_q.push_back(fcs[31:24]);
  endtask

  // One nibble sample, with an ignored rxValid=0 cycle of junk every fifth call.
  task automatic nib(input logic dv, input logic er, input logic [3:0] d);
    stall_ctr++;
    if (stall_ctr % 5 == 0) begin
      @(negedge CLOCK);
      rxValid = 1'b0;
      rxDv    = 1'($urandom_range(0, 1));
      rxEr    = 1'($urandom_range(0, 1));
      rxd     = 4'($urandom_range(0, 15));
    end
    @(negedge CLOCK);
    rxValid = 1'b1;
    rxDv    = dv;
    rxEr    = er;
    rxd     = d;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge CLOCK);
      rxValid = 1'b0;
      rxDv    = 1'b0;
      rxEr    = 1'b0;
    end
  endtask

  task automatic send_pre(input int nfive);
    repeat (nfive) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'hD);
  endtask

  task automatic send_bytes(input int er_at, input bit odd);
    foreach (tx_q[i]) begin
      nib(1'b1, (i == er_at), tx_q[i][3:0]);
      nib(1'b1, 1'b0, tx_q[i][7:4]);
    end
    if (odd) nib(1'b1, 1'b0, 4'h3);
    nib(1'b0, 1'b0, 4'h0);
  endtask

  task automatic mark();
    np0 = np_tot;
    fe0 = fe_tot;
    dv0 = dv_tot;
  endtask

  task automatic expect_frame(input string tag, input int e_np, input int e_fe, input logic e_ok,
                              input int e_bytes, input int flip,
                              input int g, input int b, input int r, input int e);
    int mism;
    int got_n;
    idle_cycles(4);
    chk({tag, "_newpkt"}, 32'(np_tot - np0), 32'(e_np));
    chk({tag, "_frameEnd"}, 32'(fe_tot - fe0), 32'(e_fe));
    if (e_fe > 0) chk({tag, "_crcOk"}, {31'd0, fe_ok}, {31'd0, e_ok});
    got_n = dv_tot - dv0;
    chk({tag, "_nbytes"}, 32'(got_n), 32'(e_bytes));
    mism = 0;
    for (int i = 0; i < e_bytes && i < got_n; i++) begin
      if (rx_mem[dv0 + i] !== (8'(i) ^ ((i == flip) ? 8'h01 : 8'h00))) mism++;
    end
    chk({tag, "_bytes"}, 32'(mism), 32'd0);
    chk({tag, "_counters"}, {goodFrames, badCrc, runts, errFrames},
        {8'(g), 8'(b), 8'(r), 8'(e)});
  endtask

  initial begin
    repeat (3) @(negedge CLOCK);
    chk("reset_outputs", {newpkt, dataValid, frameEnd, crcOk, data},
        {4'b0000, 8'h00});
    chk("reset_counters", {goodFrames, badCrc, runts, errFrames}, 32'h0);
    RESET = 1'b0;
    nib(1'b0, 1'b0, 4'h0);

    // Good 64-byte frame, full 8-byte preamble.
    mark();
    make_frame(60, -1);
    send_pre(15);
    send_bytes(-1, 1'b0);
    expect_frame("good", 1, 1, 1'b1, 60, -1, 1, 0, 0, 0);

    // Same frame, byte 10 corrupted.
    mark();
    make_frame(60, 10);
    send_pre(15);
    send_bytes(-1, 1'b0);
    expect_frame("badcrc", 1, 1, 1'b0, 60, 10, 1, 1, 0, 0);

    // 20-byte frame with valid FCS is a runt.
    mark();
    make_frame(16, -1);
    send_pre(15);
    send_bytes(-1, 1'b0);
    expect_frame("runt", 1, 1, 1'b0, 16, -1, 1, 1, 1, 0);

    // rxEr on the 30th byte.
    mark();
    make_frame(60, -1);
    send_pre(15);
    send_bytes(29, 1'b0);
    expect_frame("rxer", 1, 1, 1'b0, 25, -1, 1, 1, 1, 1);

    // Good frame right after the errored one.
    mark();
    make_frame(60, -1);
    send_pre(15);
    send_bytes(-1, 1'b0);
    expect_frame("after_er", 1, 1, 1'b1, 60, -1, 2, 1, 1, 1);

    // Ten bytes then a lone low nibble.
    mark();
    make_frame(6, -1);
    send_pre(15);
    send_bytes(-1, 1'b1);
    expect_frame("odd", 1, 1, 1'b0, 6, -1, 2, 1, 1, 2);

    // One 0x5 then SFD: rejected silently.
    mark();
    make_frame(60, -1);
    send_pre(1);
    send_bytes(-1, 1'b0);
    expect_frame("shortpre", 0, 0, 1'b0, 0, -1, 2, 1, 1, 2);

    // Reset in the middle of a frame.
    make_frame(60, -1);
    send_pre(15);
    for (int i = 0; i < 20; i++) begin
      nib(1'b1, 1'b0, tx_q[i][3:0]);
      nib(1'b1, 1'b0, tx_q[i][7:4]);
    end
    RESET = 1'b1;
    nib(1'b1, 1'b0, 4'h1);
    nib(1'b1, 1'b0, 4'h2);
    @(negedge CLOCK);
    chk("midrst_outputs", {newpkt, dataValid, frameEnd, crcOk, data},
        {4'b0000, 8'h00});
    chk("midrst_counters", {goodFrames, badCrc, runts, errFrames}, 32'h0);
    RESET = 1'b0;
    mark();
    for (int i = 20; i < 30; i++) begin
      nib(1'b1, 1'b0, tx_q[i][3:0]);
      nib(1'b1, 1'b0, tx_q[i][7:4]);
    end
    nib(1'b0, 1'b0, 4'h0);
    // Minimum accepted preamble after recovery.
    send_pre(2);
    send_bytes(-1, 1'b0);
    expect_frame("post_rst", 1, 1, 1'b1, 60, -1, 1, 0, 0, 0);

    chk("no_overlap", 32'(both_tot), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
